// File: rtl/victim_writeback_buffer_if.sv
// rtl/victim_writeback_buffer_if.sv - push, memory-write and lookup signal bundle for victim_writeback_buffer
interface victim_writeback_buffer_if #(
    parameter int CACHE_LINE_WIDTH = 128,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32
);
    logic                        push;
    logic [ADDR_WIDTH-1:0]       push_addr;
    logic [CACHE_LINE_WIDTH-1:0] push_data;
    logic                        full;
    logic                        empty;
    logic                        overflow;
    logic                        mem_write;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic                        mem_ack;
    logic [ADDR_WIDTH-1:0]       lookup_addr;
    logic                        lookup_hit;
    logic [CACHE_LINE_WIDTH-1:0] lookup_data;

    modport master (
        output push, push_addr, push_data, mem_ack, lookup_addr,
        input  full, empty, overflow, mem_write, mem_addr, mem_wdata, lookup_hit, lookup_data
    );

    modport slave (
        input  push, push_addr, push_data, mem_ack, lookup_addr,
        output full, empty, overflow, mem_write, mem_addr, mem_wdata, lookup_hit, lookup_data
    );
endinterface

// File: rtl/victim_writeback_buffer.sv
// rtl/victim_writeback_buffer.sv - posted-write line buffer draining to memory word by word; read-miss forwarding under WB_FORWARD_EN
module victim_writeback_buffer #(
    parameter int CACHE_LINE_WIDTH = 128,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int BLOCK_SIZE       = 4,
    parameter int DEPTH            = 2
) (
    input logic                    clk,
    input logic                    rst,
    victim_writeback_buffer_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int OFF_W  = $clog2(BLOCK_SIZE) + 2;
    localparam int BYTES  = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BLOCK_SIZE - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                      state_q, state_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic [DEPTH-1:0]            valid_q;
    logic [ADDR_WIDTH-1:0]       base_q [DEPTH];
    logic [CACHE_LINE_WIDTH-1:0] data_q [DEPTH];
    logic                        overflow_q;

    logic                        full_w, empty_w, push_ok, pop_w;
    logic                        mem_write_c;
    logic [ADDR_WIDTH-1:0]       mem_addr_c;
    logic [DATA_WIDTH-1:0]       mem_wdata_c;
    logic                        lookup_hit_c;
    logic [CACHE_LINE_WIDTH-1:0] lookup_data_c;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);
    // A pop in the same cycle never frees space for a push: acceptance looks at the registered count only.
    assign push_ok = bus.push && !full_w;
    assign pop_w   = (state_q == S_SEND) && bus.mem_ack && (beat_q == BEAT_LAST);

    // FSM state and beat counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state: wait for a buffered line, then step through its words on each ack.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    state_d = S_SEND;
                    beat_d  = '0;
                end
            end
            S_SEND: begin
                if (bus.mem_ack) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Memory request decoded from registered state only; zeros while idle.
    always_comb begin
        mem_write_c = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (state_q == S_SEND) begin
            mem_write_c = 1'b1;
            mem_addr_c  = base_q[rd_ptr_q] + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BYTES);
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                if (beat_q == BEAT_W'(k)) begin
                    mem_wdata_c = data_q[rd_ptr_q][k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // FIFO control: pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.push && full_w;
            if (push_ok) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_w) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push_ok && pop_w) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Line payload; only meaningful where valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            base_q[wr_ptr_q] <= bus.push_addr & BASE_MASK;
            data_q[wr_ptr_q] <= bus.push_data;
        end
    end

`ifdef WB_FORWARD_EN
    logic [ADDR_WIDTH-1:0] lookup_base;
    logic [PTR_W-1:0]      fwd_idx;

    // Scan oldest to youngest so the youngest matching entry overrides earlier ones.
    always_comb begin
        lookup_hit_c  = 1'b0;
        lookup_data_c = '0;
        fwd_idx       = '0;
        lookup_base   = bus.lookup_addr & BASE_MASK;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[fwd_idx] && (base_q[fwd_idx] == lookup_base)) begin
                lookup_hit_c  = 1'b1;
                lookup_data_c = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{bus.lookup_addr, valid_q};
    assign lookup_hit_c  = 1'b0;
    assign lookup_data_c = '0;
`endif

    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.overflow    = overflow_q;
    assign bus.mem_write   = mem_write_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.lookup_hit  = lookup_hit_c;
    assign bus.lookup_data = lookup_data_c;
endmodule
